// File: rtl/lstm_pkg.sv
// Shared defaults, gate indices, FSM state type and saturation helper for the
// sequential LSTM cell.
package lstm_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int FRACT_WIDTH_DEF = 8;

  localparam int G_F = 0;
  localparam int G_I = 1;
  localparam int G_C = 2;
  localparam int G_O = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_ACT,
    ST_UPD_C,
    ST_UPD_H,
    ST_DONE
  } state_t;

  // Clamp a wide signed value into the range of a w-bit two's-complement word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      sat = hi;
    else if (v < lo) sat = lo;
    else             sat = v;
  endfunction

endpackage

// File: rtl/lstm_act.sv
// Combinational hard activation: mode=0 hard sigmoid clamp(x/4+0.5,0,1),
// mode=1 hard tanh clamp(x,-1,1), both in signed fixed point.
module lstm_act
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FRACT_WIDTH = FRACT_WIDTH_DEF
) (
  input  logic                          mode,
  input  logic signed [DATA_WIDTH-1:0]  x,
  output logic signed [DATA_WIDTH-1:0]  y
);

  localparam int ONE_I  = 1 << FRACT_WIDTH;
  localparam int HALF_I = 1 << (FRACT_WIDTH - 1);
  localparam logic signed [DATA_WIDTH:0] ONE  = (DATA_WIDTH + 1)'(ONE_I);
  localparam logic signed [DATA_WIDTH:0] HALF = (DATA_WIDTH + 1)'(HALF_I);

  logic signed [DATA_WIDTH:0] xe;
  logic signed [DATA_WIDTH:0] r;
  logic signed [DATA_WIDTH:0] lo;

  always_comb begin
    xe = {x[DATA_WIDTH-1], x};
    if (mode) begin
      r  = xe;
      lo = -ONE;
    end else begin
      r  = (xe >>> 2) + HALF;
      lo = '0;
    end
    if (r > ONE)     r = ONE;
    else if (r < lo) r = lo;
    y = r[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/lstm_cell_seq.sv
// Sequential single-MAC LSTM cell with on-chip weight store.
// Define LSTM_CELL_SAT_EN to saturate (rather than wrap) every narrowing to DATA_WIDTH.
module lstm_cell_seq
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FRACT_WIDTH = FRACT_WIDTH_DEF,
  parameter int IN_DIM      = 2,
  parameter int HID_DIM     = 2
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic                                             seq_start,
  input  logic [IN_DIM*DATA_WIDTH-1:0]                     x_in,
  input  logic                                             w_we,
  input  logic [$clog2(4*HID_DIM*(IN_DIM+HID_DIM+1))-1:0]  w_addr,
  input  logic [DATA_WIDTH-1:0]                            w_data,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [HID_DIM*DATA_WIDTH-1:0]                    h_out,
  output logic [HID_DIM*DATA_WIDTH-1:0]                    c_out
);

  localparam int DW   = DATA_WIDTH;
  localparam int T    = IN_DIM + HID_DIM + 1;
  localparam int NU   = 4 * HID_DIM;
  localparam int NW   = NU * T;
  localparam int AW   = $clog2(NW);
  localparam int ACCW = 2 * DW + $clog2(T);
  localparam int UW   = $clog2(NU + 1);
  localparam int KW   = $clog2(T + 1);
  localparam int JW   = $clog2(HID_DIM + 1);

  function automatic logic signed [DW-1:0] narrow(input logic signed [63:0] v);
`ifdef LSTM_CELL_SAT_EN
    logic signed [63:0] s;
    s = sat(v, DW);
    narrow = s[DW-1:0];
`else
    narrow = v[DW-1:0];
`endif
  endfunction

  state_t state, nxt;
  logic [UW-1:0] u;
  logic [KW-1:0] k;
  logic [JW-1:0] j;

  logic signed [DW-1:0]   wmem   [NW];
  logic signed [DW-1:0]   x_r    [IN_DIM];
  logic signed [DW-1:0]   h_r    [HID_DIM];
  logic signed [DW-1:0]   c_r    [HID_DIM];
  logic signed [DW-1:0]   gate_r [NU];
  logic signed [ACCW-1:0] acc;

  logic [AW-1:0]            widx;
  logic signed [DW-1:0]     wsel, opnd;
  logic signed [2*DW-1:0]   prod, prod_sh, fc, ig, hp;
  logic signed [ACCW-1:0]   acc_nxt;
  logic signed [DW-1:0]     fj, ij, gj, oj, cj;
  logic signed [63:0]       csum;
  logic signed [DW-1:0]     c_new, h_new;
  logic                     act_mode;
  logic signed [DW-1:0]     act_x, act_y;

  // Unit u = g*HID_DIM + j, so the flat weight index is u*T + k.
  always_comb begin
    widx = AW'(u * T + k);
    wsel = wmem[widx];
    opnd = '0;
    for (int unsigned n = 0; n < IN_DIM; n++)
      if (k == KW'(n + 1)) opnd = x_r[n];
    for (int unsigned n = 0; n < HID_DIM; n++)
      if (k == KW'(IN_DIM + 1 + n)) opnd = h_r[n];
    prod    = opnd * wsel;
    prod_sh = prod >>> FRACT_WIDTH;
    if (k == '0) acc_nxt = ACCW'(wsel);
    else         acc_nxt = acc + ACCW'(prod_sh);
  end

  always_comb begin
    fj = '0; ij = '0; gj = '0; oj = '0; cj = '0;
    for (int unsigned n = 0; n < HID_DIM; n++)
      if (j == JW'(n)) begin
        fj = gate_r[G_F*HID_DIM + n];
        ij = gate_r[G_I*HID_DIM + n];
        gj = gate_r[G_C*HID_DIM + n];
        oj = gate_r[G_O*HID_DIM + n];
        cj = c_r[n];
      end
    fc    = fj * cj;
    ig    = ij * gj;
    csum  = 64'(fc) + 64'(ig);
    c_new = narrow(csum >>> FRACT_WIDTH);
    // The activation unit serves the gate units in ACT and tanh(c_new) in UPD_H.
    act_mode = (state == ST_UPD_H) ||
               (u >= UW'(G_C*HID_DIM) && u < UW'((G_C+1)*HID_DIM));
    act_x    = (state == ST_UPD_H) ? cj : narrow(64'(acc));
    hp       = oj * act_y;
    h_new    = narrow(64'(hp) >>> FRACT_WIDTH);
  end

  lstm_act #(.DATA_WIDTH(DW), .FRACT_WIDTH(FRACT_WIDTH)) u_act (
    .mode (act_mode),
    .x    (act_x),
    .y    (act_y)
  );

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = ST_MAC;
      end
      ST_MAC:   if (k == KW'(T - 1)) nxt = ST_ACT;
      ST_ACT:   nxt = (u == UW'(NU - 1)) ? ST_UPD_C : ST_MAC;
      ST_UPD_C: nxt = ST_UPD_H;
      ST_UPD_H: nxt = (j == JW'(HID_DIM - 1)) ? ST_DONE : ST_UPD_C;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = ST_IDLE;
      end
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      u     <= '0;
      k     <= '0;
      j     <= '0;
      acc   <= '0;
      for (int unsigned n = 0; n < NW; n++)      wmem[n]   <= '0;
      for (int unsigned n = 0; n < IN_DIM; n++)  x_r[n]    <= '0;
      for (int unsigned n = 0; n < HID_DIM; n++) h_r[n]    <= '0;
      for (int unsigned n = 0; n < HID_DIM; n++) c_r[n]    <= '0;
      for (int unsigned n = 0; n < NU; n++)      gate_r[n] <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        ST_IDLE: begin
          if (w_we && ({1'b0, w_addr} < (AW + 1)'(NW))) wmem[w_addr] <= w_data;
          if (in_valid) begin
            for (int unsigned n = 0; n < IN_DIM; n++) x_r[n] <= x_in[n*DW +: DW];
            u <= '0;
            k <= '0;
            if (seq_start)
              for (int unsigned n = 0; n < HID_DIM; n++) begin
                h_r[n] <= '0;
                c_r[n] <= '0;
              end
          end
        end
        ST_MAC: begin
          acc <= acc_nxt;
          k   <= k + 1'b1;
        end
        ST_ACT: begin
          for (int unsigned n = 0; n < NU; n++)
            if (u == UW'(n)) gate_r[n] <= act_y;
          u <= u + 1'b1;
          k <= '0;
          j <= '0;
        end
        ST_UPD_C: begin
          for (int unsigned n = 0; n < HID_DIM; n++)
            if (j == JW'(n)) c_r[n] <= c_new;
        end
        ST_UPD_H: begin
          for (int unsigned n = 0; n < HID_DIM; n++)
            if (j == JW'(n)) h_r[n] <= h_new;
          j <= j + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    h_out = '0;
    c_out = '0;
    for (int unsigned n = 0; n < HID_DIM; n++) begin
      h_out[n*DW +: DW] = h_r[n];
      c_out[n*DW +: DW] = c_r[n];
    end
  end

endmodule

// File: doc/lstm_cell_seq.md
LSTM_CELL_SEQ -- requirements
Module: lstm_cell_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed fixed-point word width.
REQ-002 Parameter FRACT_WIDTH, default 8, fractional bits (Q8.8 at defaults).
REQ-003 Parameter IN_DIM, default 2, input vector length.
REQ-004 Parameter HID_DIM, default 2, hidden/cell vector length.
REQ-005 Port clk, input, 1, sole clock; all state rising-edge.
REQ-006 Port rst, input, 1, reset, asynchronous assert, active-low.
REQ-007 Port in_valid, input, 1, x_in valid.
REQ-008 Port in_ready, output, 1, block accepts a time step.
REQ-009 Port seq_start, input, 1, qualified by in_valid&&in_ready; zero c/h state before this step.
REQ-010 Port x_in, input, IN_DIM*DATA_WIDTH, input vector; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 Port w_we, input, 1, weight/bias write strobe.
REQ-012 Port w_addr, input, clog2(4*HID_DIM*(IN_DIM+HID_DIM+1)), weight address.
REQ-013 Port w_data, input, DATA_WIDTH, weight/bias value.
REQ-014 Port out_valid, output, 1, h_out/c_out hold a completed step.
REQ-015 Port out_ready, input, 1, consumer accepts result.
REQ-016 Port h_out, output, HID_DIM*DATA_WIDTH, hidden state vector, same packing as x_in.
REQ-017 Port c_out, output, HID_DIM*DATA_WIDTH, cell state vector, same packing.

Function
REQ-018 Weight layout: addr = (g*HID_DIM + j)*(IN_DIM+HID_DIM+1) + k; gate g: 0=f,1=i,2=c,3=o; k=0 bias, k=1..IN_DIM x, k>IN_DIM h_prev.
REQ-019 Writes with w_we=1 take effect only in IDLE; ignored in other states; out-of-range addresses ignored.
REQ-020 FSM states IDLE, MAC, ACT, UPD_C, UPD_H, DONE; in_ready=1 only in IDLE.
REQ-021 IDLE->MAC on in_valid&&in_ready; x_in captured that cycle; seq_start clears c and h registers in the same cycle.
REQ-022 MAC: one term per cycle, bias first then W*x then W*h_prev; products arithmetic-shifted right by FRACT_WIDTH; accumulator width 2*DATA_WIDTH+clog2(IN_DIM+HID_DIM+1).
REQ-023 ACT: one cycle per gate-unit; accumulator narrowed to DATA_WIDTH, activation applied, stored in gate register; then next gate-unit MAC or, after last, UPD_C for j=0.
REQ-024 f,i,o use hard sigmoid: clamp(x/4 + 0.5, 0, 1.0); c-candidate uses hard tanh: clamp(x, -1.0, 1.0).
REQ-025 UPD_C: c_j = (f_j*c_j + i_j*g_j)>>>FRACT_WIDTH; UPD_H: h_j = (o_j*tanh_hard(c_j_new))>>>FRACT_WIDTH; j iterates 0..HID_DIM-1.
REQ-026 All gates use h_prev of the previous step; h/c registers change only in UPD_C/UPD_H.
REQ-027 Latency accept->out_valid exactly 4*HID_DIM*(IN_DIM+HID_DIM+2) + 2*HID_DIM cycles (52 at defaults).
REQ-028 DONE: out_valid=1 held, h_out/c_out stable until out_ready=1; then IDLE the next cycle; h/c retained for the next step.
REQ-029 out_ready ignored outside DONE; in_valid ignored outside IDLE.

Reset
REQ-030 rst=0 forces IDLE, in_ready=1 after release, out_valid=0, h/c/gate/accumulator registers 0, all weights 0.
REQ-031 Reset mid-computation abandons the step; no partial result ever appears on h_out/c_out.

Configuration
REQ-032 Macro LSTM_CELL_SAT_EN defined: every narrowing to DATA_WIDTH (ACT, UPD_C, UPD_H) saturates to [0x8000, 0x7FFF] at defaults.
REQ-033 Macro undefined: narrowing truncates (two's-complement wrap); all else identical.

Structure
REQ-034 Package lstm_pkg holds default DATA_WIDTH/FRACT_WIDTH, gate index constants, FSM state enum, saturate function.
REQ-035 Sub-module lstm_act (combinational hard sigmoid/hard tanh, mode select input) instantiated once, shared by ACT and UPD_H.

Verification
REQ-036 Reset, all weights 0, step with x=0 -> after 52 cycles h_out=0, c_out=0 (sigmoid=0x0080, tanh=0).
REQ-037 bf=bi=bo=0x0400, bc=0x0080, other weights 0, seq_start=1 -> c=0x0080, h=0x0080; next step (seq_start=0) c=0x0100, h=0x0100; third c=0x0180, h=0x0100.
REQ-038 Repeat REQ-037 third step with seq_start=1 -> c=0x0080, h=0x0080.
REQ-039 bc=0x7F00, Wc x-weight 0x7F00, x=0x7F00: SAT_EN -> candidate clamps +1.0, no wrap; without macro pre-activation wraps negative.
REQ-040 Hold out_ready=0 10 cycles -> out_valid, outputs stable, in_ready=0; w_we in DONE leaves weights unchanged.
REQ-041 Assert rst at cycle 20 of a step -> out_valid=0, h/c=0, next step matches fresh-reset result.
